// File: rtl/cmem_pp.sv
// Ping-pong coefficient memory: one active bank serves reads while the shadow bank
// is loaded, then the banks swap. Optional word-count check: define CMEM_PP_WCNT_CHECK_EN.
module cmem_pp #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              cload,
  input  logic [ADDR_W-1:0] caddr,
  input  logic [WIDTH-1:0]  cin,
  input  logic              load_done,
  input  logic              swap_req,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  cout,
  output logic              cvalid,
  output logic              bank_sel,
  output logic              shadow_rdy,
  output logic              swap_ack,
  output logic              load_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t state;

  // Both banks live in one array; the bank index is the address MSB.
  logic [WIDTH-1:0] mem [0:2*DEPTH-1];

  logic wr_en;
  logic swap_go;

  // A READY shadow is frozen; reset blocks writes too.
  assign wr_en   = cload && (state != READY) && !rst;
  assign swap_go = (state == READY) && swap_req;

  always_ff @(posedge clk2) begin
    if (wr_en) begin
      mem[{~bank_sel, caddr}] <= cin;
    end
  end

  // Read uses the pre-edge bank_sel, so a read coinciding with a swap sees the old bank.
  always_ff @(posedge clk2) begin
    if (rst) begin
      cout   <= '0;
      cvalid <= 1'b0;
    end else begin
      cvalid <= ren;
      if (ren) begin
        cout <= mem[{bank_sel, raddr}];
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state      <= EMPTY;
      bank_sel   <= 1'b0;
      shadow_rdy <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        EMPTY: begin
          if (cload) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (load_done) begin
            state      <= READY;
            shadow_rdy <= 1'b1;
          end
        end
        READY: begin
          if (swap_go) begin
            state      <= EMPTY;
            shadow_rdy <= 1'b0;
            bank_sel   <= ~bank_sel;
            swap_ack   <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          shadow_rdy <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMEM_PP_WCNT_CHECK_EN
  logic [ADDR_W:0] wcnt;
  logic [ADDR_W:0] wcnt_inc;

  // Saturating count of accepted writes, repeated addresses included.
  always_comb begin
    wcnt_inc = wcnt;
    if (wr_en && (wcnt != '1)) begin
      wcnt_inc = wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      wcnt     <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (swap_go) begin
        wcnt <= '0;
      end else begin
        wcnt <= wcnt_inc;
      end
      // A write in the same cycle as load_done is counted before the check.
      if ((state == LOAD) && load_done && (wcnt_inc != (ADDR_W+1)'(DEPTH))) begin
        load_err <= 1'b1;
      end
    end
  end
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmem_pp.sv
// Self-checking bench for cmem_pp: directed scenarios plus random traffic
// compared against an array-based model of the two banks and the load/swap rules.
module tb_cmem_pp;
  localparam int DEPTH  = 64;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 6;

  logic              clk2;
  logic              rst;
  logic              cload;
  logic [ADDR_W-1:0] caddr;
  logic [WIDTH-1:0]  cin;
  logic              load_done;
  logic              swap_req;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [WIDTH-1:0]  cout;
  logic              cvalid;
  logic              bank_sel;
  logic              shadow_rdy;
  logic              swap_ack;
  logic              load_err;

  // clock / reset
  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  cmem_pp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk2(clk2), .rst(rst), .cload(cload), .caddr(caddr), .cin(cin),
    .load_done(load_done), .swap_req(swap_req), .ren(ren), .raddr(raddr),
    .cout(cout), .cvalid(cvalid), .bank_sel(bank_sel), .shadow_rdy(shadow_rdy),
    .swap_ack(swap_ack), .load_err(load_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: phase 0=empty 1=loading 2=ready
  int               m_sel = 0;
  int               m_ph  = 0;
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_bank [2][DEPTH];
  bit               m_ok   [2][DEPTH];
  logic [WIDTH-1:0] e_cout = '0;
  bit               e_cout_ok = 1'b0;
  bit               e_cvalid = 1'b0;
  bit               e_ack = 1'b0;
  bit               e_err = 1'b0;

  task automatic model_step();
    int ph0;
    if (rst) begin
      m_sel = 0; m_ph = 0; m_cnt = 0;
      e_cout = '0; e_cout_ok = 1'b1;
      e_cvalid = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    end else begin
      ph0 = m_ph;
      e_ack = 1'b0;
      e_err = 1'b0;
      e_cvalid = ren;
      if (ren) begin
        e_cout    = m_bank[m_sel][raddr];
        e_cout_ok = m_ok[m_sel][raddr];
      end
      if (cload && ph0 != 2) begin
        m_bank[1-m_sel][caddr] = cin;
        m_ok[1-m_sel][caddr]   = 1'b1;
        if (m_cnt < 2**(ADDR_W+1) - 1) m_cnt++;
        m_ph = 1;
      end
      if (ph0 == 1 && load_done) begin
        m_ph = 2;
`ifdef CMEM_PP_WCNT_CHECK_EN
        e_err = (m_cnt != DEPTH);
`endif
      end
      if (ph0 == 2 && swap_req) begin
        m_sel = 1 - m_sel;
        m_ph  = 0;
        m_cnt = 0;
        e_ack = 1'b1;
      end
    end
  endtask

  // one clock: model follows the same inputs, outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk2);
    model_step();
    #1;
    check("bank_sel", 32'(bank_sel), 32'(m_sel));
    check("shadow_rdy", 32'(shadow_rdy), 32'(m_ph == 2));
    check("cvalid", 32'(cvalid), 32'(e_cvalid));
    check("swap_ack", 32'(swap_ack), 32'(e_ack));
    check("load_err", 32'(load_err), 32'(e_err));
    if (e_cout_ok) check("cout", 32'(cout), 32'(e_cout));
    rst = 1'b0; cload = 1'b0; load_done = 1'b0; swap_req = 1'b0; ren = 1'b0;
  endtask

  // kind 0: addr*16, kind 1: -addr, otherwise random data
  task automatic load_seq(input int n, input int kind, input bit rd, input int ra);
    for (int a = 0; a < n; a++) begin
      cload = 1'b1;
      caddr = ADDR_W'(a);
      case (kind)
        0:       cin = WIDTH'(a * 16);
        1:       cin = WIDTH'(-a);
        default: cin = WIDTH'($urandom);
      endcase
      if (rd) begin
        ren = 1'b1;
        raddr = ADDR_W'(ra);
      end
      step();
    end
  endtask

  bit exp_err_bad;

  initial begin
    rst = 1'b1; cload = 1'b0; caddr = '0; cin = '0; load_done = 1'b0;
    swap_req = 1'b0; ren = 1'b0; raddr = '0;
`ifdef CMEM_PP_WCNT_CHECK_EN
    exp_err_bad = 1'b1;
`else
    exp_err_bad = 1'b0;
`endif

    rst = 1'b1; step();
    rst = 1'b1; step();
    check("rst_bank_sel", 32'(bank_sel), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_rdy", 32'(shadow_rdy), 0);

    // first load into bank 1, swap, read back
    load_seq(DEPTH, 0, 1'b0, 0);
    load_done = 1'b1; step();
    check("r021_rdy", 32'(shadow_rdy), 1);
    swap_req = 1'b1; step();
    check("r021_ack", 32'(swap_ack), 1);
    check("r021_sel", 32'(bank_sel), 1);
    ren = 1'b1; raddr = 6'd5; step();
    check("r021_cout", 32'(cout), 32'd80);
    check("r021_cvalid", 32'(cvalid), 1);
    step();
    check("r021_hold_cvalid", 32'(cvalid), 0);
    check("r021_hold_cout", 32'(cout), 32'd80);

    // reads of the active bank stay stable while the shadow loads
    load_seq(DEPTH, 1, 1'b1, 10);
    check("r022_during", 32'(cout), 32'd160);
    load_done = 1'b1; step();
    swap_req = 1'b1; step();
    ren = 1'b1; raddr = 6'd10; step();
    check("r022_after", 32'(cout), 32'h0000_FFF6);

    // read coinciding with swap returns the old bank
    load_seq(DEPTH, 2, 1'b0, 0);
    load_done = 1'b1; step();
    swap_req = 1'b1; ren = 1'b1; raddr = 6'd3; step();
    check("r023_old", 32'(cout), 32'h0000_FFFD);
    ren = 1'b1; raddr = 6'd3; step();
    check("r023_new", 32'(cout), 32'(m_bank[1][3]));

    // swap ignored in EMPTY and LOAD; writes dropped in READY
    swap_req = 1'b1; step();
    check("r024_empty_ack", 32'(swap_ack), 0);
    check("r024_empty_sel", 32'(bank_sel), 1);
    load_seq(5, 0, 1'b0, 0);
    swap_req = 1'b1; step();
    check("r024_load_ack", 32'(swap_ack), 0);
    check("r024_load_sel", 32'(bank_sel), 1);
    load_done = 1'b1; step();
    cload = 1'b1; caddr = 6'd0; cin = 16'h1234; step();
    swap_req = 1'b1; step();
    check("r024_sel", 32'(bank_sel), 0);
    ren = 1'b1; raddr = 6'd0; step();
    check("r024_keep", 32'(cout), 0);

    // word-count check: short, exact and saturated loads
    load_seq(DEPTH - 1, 2, 1'b0, 0);
    load_done = 1'b1; step();
    check("r025_err63", 32'(load_err), 32'(exp_err_bad));
    check("r025_rdy63", 32'(shadow_rdy), 1);
    step();
    check("r025_pulse", 32'(load_err), 0);
    swap_req = 1'b1; step();
    load_seq(DEPTH, 2, 1'b0, 0);
    load_done = 1'b1; step();
    check("r025_err64", 32'(load_err), 0);
    swap_req = 1'b1; step();
    load_seq(130, 2, 1'b0, 0);
    load_done = 1'b1; step();
    check("r025_err130", 32'(load_err), 32'(exp_err_bad));
    swap_req = 1'b1; step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cload     = 1'($urandom_range(0, 1));
      caddr     = ADDR_W'($urandom);
      cin       = WIDTH'($urandom);
      load_done = ($urandom_range(0, 15) == 0);
      swap_req  = ($urandom_range(0, 7) == 0);
      ren       = 1'($urandom_range(0, 1));
      raddr     = ADDR_W'($urandom);
      step();
    end

    // reset mid-load discards progress
    rst = 1'b1; step();
    load_seq(20, 2, 1'b0, 0);
    rst = 1'b1; step();
    check("r026_rdy", 32'(shadow_rdy), 0);
    check("r026_sel", 32'(bank_sel), 0);
    check("r026_cout", 32'(cout), 0);
    load_done = 1'b1; step();
    check("r026_ignored", 32'(shadow_rdy), 0);
    swap_req = 1'b1; step();
    check("r026_noswap", 32'(swap_ack), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cmem_pp.md
CMEM_PP -- requirements
Module: cmem_pp

Interface
REQ-001 Parameters SHALL be (one per line):
  DEPTH   64   coefficient words per bank
  WIDTH   16   signed coefficient width (Q1.(WIDTH-1))
  ADDR_W  6    address width, equals clog2(DEPTH)
REQ-002 Ports SHALL be (one per line):
  clk2        in   1       single clock, all logic on rising edge
  rst         in   1       synchronous, active-high reset
  cload       in   1       write strobe into shadow bank
  caddr       in   ADDR_W  write address
  cin         in   WIDTH   signed write data
  load_done   in   1       pulse, shadow load complete
  swap_req    in   1       pulse, request shadow/active exchange
  ren         in   1       read enable, active bank
  raddr       in   ADDR_W  read address
  cout        out  WIDTH   signed registered read data
  cvalid      out  1       cout updated this cycle
  bank_sel    out  1       index of active bank (0/1)
  shadow_rdy  out  1       shadow bank in READY
  swap_ack    out  1       one-cycle pulse, swap performed
  load_err    out  1       one-cycle pulse, word-count mismatch
REQ-003 The block SHALL use one clock (clk2); the reset (rst) SHALL be synchronous and active-high.

Function
REQ-004 Storage: two banks of DEPTH x WIDTH; active bank = bank_sel, shadow bank = ~bank_sel.
REQ-005 Read: ren=1 at edge N SHALL load cout with active[raddr] at edge N; cvalid=1 for that cycle only; ren=0 holds cout, cvalid=0.
REQ-006 Read latency SHALL be exactly 1 cycle; back-to-back reads every cycle SHALL be supported.
REQ-007 Shadow FSM states SHALL be EMPTY, LOAD, READY; shadow_rdy=1 only in READY.
REQ-008 EMPTY/LOAD + cload: write shadow[caddr]=cin, increment word counter, go/stay LOAD.
REQ-009 LOAD + load_done: go READY; a cload in the same cycle SHALL be written and counted first.
REQ-010 EMPTY + load_done: ignored, no state change.
REQ-011 READY + cload: write SHALL be dropped; shadow contents unchanged; stay READY.
REQ-012 READY + swap_req: bank_sel toggles at that edge, swap_ack=1 next cycle, go EMPTY, word counter cleared.
REQ-013 swap_req outside READY: ignored, swap_ack stays 0, bank_sel unchanged.
REQ-014 swap_req and ren same cycle: read SHALL return data from the pre-swap active bank.
REQ-015 Word counter SHALL be ADDR_W+1 bits, saturate at 2^(ADDR_W+1)-1, and count writes including repeated addresses.
REQ-016 Writes SHALL never touch the active bank; reads SHALL never see shadow data before swap.

Reset
REQ-017 On rst=1 at an edge: bank_sel=0, FSM=EMPTY, counter=0, cout=0, cvalid=0, swap_ack=0, load_err=0, shadow_rdy=0.
REQ-018 Memory contents SHALL NOT be reset; reset mid-load discards load progress (FSM EMPTY) and takes priority over all inputs.

Configuration
REQ-019 Macro CMEM_PP_WCNT_CHECK_EN defined: load_done accepted in LOAD with counter != DEPTH SHALL pulse load_err for one cycle; FSM still goes READY.
REQ-020 Macro undefined: load_err SHALL be constant 0; counter logic may be removed; all other behaviour identical.

Verification
REQ-021 Reset; write 0..63 with cin=addr*16, load_done, swap_req -> swap_ack pulse, bank_sel=1; read addr 5 -> cout=80 one cycle later, cvalid=1.
REQ-022 Bank 1 active, load bank 0 with -addr, read raddr=10 every cycle during load -> cout=160 throughout; after swap, cout=-10.
REQ-023 swap_req with ren=1 raddr=3 same cycle -> cout = old-bank word 3; next read raddr=3 -> new-bank word.
REQ-024 swap_req in EMPTY and in LOAD -> no swap_ack, bank_sel unchanged; cload in READY to addr 0 -> addr 0 retains old value after swap.
REQ-025 WCNT_CHECK_EN defined: 63 writes then load_done -> load_err pulse 1 cycle, shadow_rdy=1; 64 writes -> no load_err; undefined -> load_err always 0.
REQ-026 rst asserted after 20 writes -> shadow_rdy=0, bank_sel=0, cout=0; load_done alone then ignored.
